seg_scan_4: RTL and testbench

SEG_SCAN_4 -- requirements
Module: seg_scan_4

---
 rtl/seg_scan_4_pkg.sv | 32 +++
 rtl/seg_scan_4_hex_to_seg.sv | 11 +
 rtl/seg_scan_4.sv | 122 ++++++++++++
 tb/tb_seg_scan_4.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_4_pkg.sv
// Shared constants for the 4-digit multiplexed seven-segment scanner.
package seg_scan_4_pkg;

   localparam int NUM_DIGITS = 4;

   typedef logic [3:0] nibble_t;
   typedef logic [1:0] digit_idx_t;
   typedef logic [6:0] seg_t;

   // Segment order {g,f,e,d,c,b,a}, active-low.
   localparam seg_t SEG_BLANK = 7'b1111111;

   localparam seg_t SEG_TABLE [0:15] = '{
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000,  // 9
      7'b0001000,  // A
      7'b0000011,  // b
      7'b1000110,  // C
      7'b0100001,  // d
      7'b0000110,  // E
      7'b0001110   // F
   };

endpackage

// File: rtl/seg_scan_4_hex_to_seg.sv
// Combinational hex digit to active-low segment pattern decoder.
module hex_to_seg
   import seg_scan_4_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg_scan_4.sv
// Time-multiplexed 4-digit seven-segment driver with frame-coherent digit
// snapshots, leading-zero blanking and a sticky overflow indicator on DP.
module seg_scan_4
   import seg_scan_4_pkg::*;
#(
   parameter int SCAN_DIV = 50000
)(
   input  logic       CP,
   input  logic       Rd,
   input  logic       EN,
   input  logic [3:0] DIG0,
   input  logic [3:0] DIG1,
   input  logic [3:0] DIG2,
   input  logic [3:0] DIG3,
   input  logic       C_IN,
   input  logic       CLR_OVF,
   input  logic       LZB,
   output logic [3:0] AN,
   output logic [6:0] SEG,
   output logic       DP,
   output logic       OVF
);

   localparam int                CNT_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   digit_idx_t       idx_q, idx_d;
   logic             ovf_q, ovf_d;
   logic [3:0]       an_q,  an_d;
   seg_t             seg_q, seg_d;
   logic             dp_q,  dp_d;

   nibble_t          dig_in [NUM_DIGITS];
   nibble_t          snap_q [NUM_DIGITS];
   logic             blank  [NUM_DIGITS];
   logic             tick;
   logic             frame_end;
   seg_t             dec_seg;

   assign dig_in[0] = DIG0;
   assign dig_in[1] = DIG1;
   assign dig_in[2] = DIG2;
   assign dig_in[3] = DIG3;

   assign tick      = EN && (cnt_q == CNT_MAX);
   assign frame_end = tick && (idx_q == 2'd3);

   // Blanking chains down from the top digit: a digit is blanked only when
   // it and every digit above it are zero. Digit 0 is always shown.
   assign blank[NUM_DIGITS-1] = LZB && (snap_q[NUM_DIGITS-1] == 4'd0);
   generate
      for (genvar gi = NUM_DIGITS - 2; gi >= 1; gi--) begin : g_blank
         assign blank[gi] = blank[gi+1] && (snap_q[gi] == 4'd0);
      end
   endgenerate
   assign blank[0] = 1'b0;

   // Snapshots refresh together at frame end so a frame never mixes digits.
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_snap
         always_ff @(posedge CP) begin
            if (!Rd)            snap_q[gi] <= 4'd0;
            else if (frame_end) snap_q[gi] <= dig_in[gi];
         end
      end
   endgenerate

   hex_to_seg u_dec (
      .hex (snap_q[idx_q]),
      .seg (dec_seg)
   );

   // Next-state for prescaler, digit index, overflow flag and display outputs.
   always_comb begin
      cnt_d = cnt_q;
      idx_d = idx_q;
      if (EN) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
         if (tick) idx_d = idx_q + 2'd1;
      end

      // Set has priority over clear.
      ovf_d = ovf_q;
      if (C_IN)         ovf_d = 1'b1;
      else if (CLR_OVF) ovf_d = 1'b0;

      an_d  = 4'b1111;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
      if (EN) begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = blank[idx_q] ? SEG_BLANK : dec_seg;
         dp_d  = ~((idx_q == 2'd3) && ovf_q);
      end
   end

   // State and output registers; reset dominates every other input.
   always_ff @(posedge CP) begin
      if (!Rd) begin
         cnt_q <= '0;
         idx_q <= '0;
         ovf_q <= 1'b0;
         an_q  <= 4'b1111;
         seg_q <= SEG_BLANK;
         dp_q  <= 1'b1;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         ovf_q <= ovf_d;
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign AN  = an_q;
   assign SEG = seg_q;
   assign DP  = dp_q;
   assign OVF = ovf_q;

endmodule

// File: tb/tb_seg_scan_4.sv
// Randomised and directed bench for seg_scan_4 against a frame-level model.
module tb_seg_scan_4;

   localparam int DIV = 4;

   logic       cp = 1'b0;
   logic       rd = 1'b0;
   logic       en = 1'b0;
   logic       c_in = 1'b0;
   logic       clr_ovf = 1'b0;
   logic       lzb = 1'b0;
   logic [3:0] dig [4];
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       ovf;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Model: total enabled cycles since reset determines slot and index.
   int         en_cycles = 0;
   logic [3:0] m_snap [4];
   logic       m_ovf = 1'b0;
   logic [3:0] exp_an;
   logic [6:0] exp_seg;
   logic       exp_dp;

   always #5 cp = ~cp;

   seg_scan_4 #(.SCAN_DIV(DIV)) dut (
      .CP      (cp),
      .Rd      (rd),
      .EN      (en),
      .DIG0    (dig[0]),
      .DIG1    (dig[1]),
      .DIG2    (dig[2]),
      .DIG3    (dig[3]),
      .C_IN    (c_in),
      .CLR_OVF (clr_ovf),
      .LZB     (lzb),
      .AN      (an),
      .SEG     (seg),
      .DP      (dp),
      .OVF     (ovf)
   );

   function automatic logic [6:0] ref_seg(input logic [3:0] v);
      case (v)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, expv);
      end
   endtask

   // One clock: predict from pre-edge state and inputs, then compare.
   task automatic step();
      int   idx;
      logic blk;
      if (!rd) begin
         en_cycles = 0;
         for (int k = 0; k < 4; k++) m_snap[k] = 4'd0;
         m_ovf   = 1'b0;
         exp_an  = 4'b1111;
         exp_seg = 7'b1111111;
         exp_dp  = 1'b1;
      end else begin
         if (en) begin
            idx    = (en_cycles / DIV) % 4;
            exp_an = ~(4'b0001 << idx);
            blk    = 1'b0;
            if (lzb && idx > 0) begin
               blk = 1'b1;
               for (int k = idx; k < 4; k++)
                  if (m_snap[k] != 4'd0) blk = 1'b0;
            end
            exp_seg = blk ? 7'b1111111 : ref_seg(m_snap[idx]);
            exp_dp  = !(idx == 3 && m_ovf);
         end else begin
            exp_an  = 4'b1111;
            exp_seg = 7'b1111111;
            exp_dp  = 1'b1;
         end
         if (c_in)         m_ovf = 1'b1;
         else if (clr_ovf) m_ovf = 1'b0;
         if (en) begin
            en_cycles++;
            if (en_cycles % (4 * DIV) == 0) m_snap = dig;
         end
      end
      @(posedge cp);
      #1;
      cyc++;
      $display("cyc=%0d rd=%b en=%b lzb=%b cin=%b clr=%b an=%b seg=%b dp=%b ovf=%b",
               cyc, rd, en, lzb, c_in, clr_ovf, an, seg, dp, ovf);
      check_val("AN",  32'(an),  32'(exp_an));
      check_val("SEG", 32'(seg), 32'(exp_seg));
      check_val("DP",  32'(dp),  32'(exp_dp));
      check_val("OVF", 32'(ovf), 32'(m_ovf));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      for (int k = 0; k < 4; k++) begin
         dig[k]    = 4'd0;
         m_snap[k] = 4'd0;
      end

      // Reset, then scan 1,2,3,4 (DIG3..DIG0).
      rd = 1'b0;
      run(2);
      rd = 1'b1; en = 1'b1;
      dig[3] = 4'd1; dig[2] = 4'd2; dig[1] = 4'd3; dig[0] = 4'd4;
      step();
      check_val("first_an", 32'(an), 32'(4'b1110));
      check_val("first_seg_zero", 32'(seg), 32'(7'b1000000));
      run(15);
      step();
      check_val("frame2_dig0", 32'(seg), 32'(7'b0011001));
      run(15);

      // Inputs change mid-frame.
      run(5);
      dig[3] = 4'hA; dig[2] = 4'hB; dig[1] = 4'hC; dig[0] = 4'hD;
      run(40);

      // Leading-zero blanking with 0,0,0,7.
      lzb = 1'b1;
      dig[3] = 4'd0; dig[2] = 4'd0; dig[1] = 4'd0; dig[0] = 4'd7;
      run(40);
      lzb = 1'b0;

      // Overflow set / set-wins / clear sequence.
      c_in = 1'b1; step(); c_in = 1'b0;
      run(20);
      c_in = 1'b1; clr_ovf = 1'b1; step(); c_in = 1'b0; clr_ovf = 1'b0;
      run(20);
      clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
      run(20);

      // Freeze mid-frame for 10 cycles.
      run(6);
      en = 1'b0;
      run(10);
      en = 1'b1;
      run(20);

      // Reset while index 2 is about to be displayed.
      for (int i = 0; i < 64 && ((en_cycles / DIV) % 4) != 2; i++) step();
      check_val("reached_idx2", 32'((en_cycles / DIV) % 4), 32'd2);
      rd = 1'b0;
      step();
      rd = 1'b1;
      step();
      check_val("post_reset_an", 32'(an), 32'(4'b1110));
      run(20);

      // Randomised traffic.
      for (int i = 0; i < 800; i++) begin
         rd      = ($urandom_range(0, 63) != 0);
         en      = ($urandom_range(0, 7) != 0);
         c_in    = ($urandom_range(0, 31) == 0);
         clr_ovf = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 31) == 0) lzb = ~lzb;
         if ($urandom_range(0, 7) == 0)
            for (int k = 0; k < 4; k++)
               dig[k] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
